// File: rtl/elastic_pkg.sv
// Shared constants and helpers for the elastic pipeline and its stages.
package elastic_pkg;

    localparam int MAX_DEPTH = 16;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/data register pair of the elastic pipeline with its ready term.
module elastic_stage
    import elastic_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             rdy,
    output logic             valid,
    output logic             valid_next,
    output logic [WIDTH-1:0] data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // An empty stage always accepts, which is what collapses bubbles.
    assign rdy        = !valid_reg || dn_ready;
    assign valid_next = flush ? 1'b0 : (rdy ? up_valid : valid_reg);
    assign valid      = valid_reg;
    assign data       = data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= RESET_DATA;
        end else if (flush) begin
            valid_reg <= 1'b0;
            data_reg  <= RESET_DATA;
        end else begin
            valid_reg <= valid_next;
            if (rdy && up_valid) begin
                data_reg <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// DEPTH-stage valid/ready register pipeline with flush and a registered occupancy count.
module elastic_pipeline
    import elastic_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        flush,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("elastic_pipeline: DEPTH out of range 1..16");
    end

    logic [DEPTH:0]   rdy_chain;
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_valid_next;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [OCC_W-1:0] occupancy_reg;
    logic [OCC_W-1:0] occupancy_next;

    assign rdy_chain[DEPTH] = out_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (gi == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = stage_valid[gi-1];
            assign up_data  = stage_data[gi-1];
        end

        elastic_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .dn_ready   (rdy_chain[gi+1]),
            .rdy        (rdy_chain[gi]),
            .valid      (stage_valid[gi]),
            .valid_next (stage_valid_next[gi]),
            .data       (stage_data[gi])
        );
    end

    // Popcount the next-state valids so the count never lags the stages.
    always_comb begin
        occupancy_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_next = occupancy_next + OCC_W'(stage_valid_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    assign in_ready  = rst && rdy_chain[0] && !flush;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Scoreboard bench for elastic_pipeline with WIDTH=8, DEPTH=3.
module tb_elastic_pipeline;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    typedef struct {
        logic [7:0] d;
        int         c;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       occupancy;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    beats = 0;
    bit    lat_chk = 0;

    elastic_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample handshakes at the falling edge, then advance to just after the next rising edge.
    task automatic cycle();
        beat_t b;
        bit in_fire;
        bit out_fire;
        @(negedge clk);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        check("occ", 32'(occupancy), 32'(sb.size()));
        if (out_fire) begin
            if (sb.size() == 0) begin
                check("stale", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                b = sb.pop_front();
                beats++;
                $display("beat %0d out=%02h cycle=%0d", beats, out_data, cyc);
                check("data", 32'(out_data), 32'(b.d));
                if (lat_chk) check("lat", 32'(cyc - b.c), 32'(DEPTH));
            end
        end
        if (flush) sb.delete();
        else if (in_fire) sb.push_back('{d: in_data, c: cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_odata", 32'(out_data), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_iready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("iready_idle", 32'(in_ready), 32'd1);

        // Reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, 8'h11); cycle();
        drive(1'b1, 8'h22); cycle();
        drive(1'b0, 8'h00); cycle();
        check("pre_rst_ovalid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_ovalid", 32'(out_valid), 32'd0);
        check("midrst_odata", 32'(out_data), 32'd0);
        check("midrst_iready", 32'(in_ready), 32'd0);
        check("midrst_occ", 32'(occupancy), 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        repeat (5) cycle();
        check("post_rst_occ", 32'(occupancy), 32'd0);

        // Streaming with fixed latency
        lat_chk = 1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i));
            #1 check("stream_iready", 32'(in_ready), 32'd1);
            cycle();
        end
        drain();
        lat_chk = 0;

        // Backpressure fill
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i));
            #1 check("fill_iready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
            if (i == 3) check("fill_occ", 32'(occupancy), 32'd3);
            if (i < 3) cycle();
        end
        out_ready = 1'b1;
        #1 check("fill_release_iready", 32'(in_ready), 32'd1);
        cycle();
        drain();

        // Bubble collapse
        out_ready = 1'b0;
        drive(1'b1, 8'h55); cycle();
        drive(1'b0, 8'h00); cycle(); cycle();
        drive(1'b1, 8'h66); cycle();
        drive(1'b0, 8'h00); cycle();
        check("bubble_occ", 32'(occupancy), 32'd2);
        check("bubble_head", 32'(out_data), 32'h55);
        out_ready = 1'b1;
        cycle();
        check("bubble_b2b_valid", 32'(out_valid), 32'd1);
        check("bubble_b2b_data", 32'(out_data), 32'h66);
        drain();

        // Full plus simultaneous accept/emit
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hC1 + 8'(i));
            cycle();
        end
        drive(1'b1, 8'h77);
        #1 check("full_iready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1 check("simul_iready", 32'(in_ready), 32'd1);
        cycle();
        check("simul_occ", 32'(occupancy), 32'd3);
        drain();

        // Flush
        out_ready = 1'b0;
        drive(1'b1, 8'hB0); cycle();
        drive(1'b1, 8'hB1); cycle();
        drive(1'b1, 8'hCC);
        flush = 1'b1;
        #1 check("flush_iready", 32'(in_ready), 32'd0);
        cycle();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        #1;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_ovalid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (6) cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
